rv_mem_ws: RTL and testbench
============================

// Module: rv_mem_ws
// PURPOSE
//  Unified instruction/data memory for the 5-stage core, with per-port parametrised wait states.
//  Separate IMEM (word) and DMEM (byte) arrays; each port has a ready/busy handshake so the pipeline can stall.
//  Adds byte-lane loads/stores with sign/zero extension, and misalign/out-of-range error reporting.
//  Serves as the memory of the core testbench and the simulation top.
// PARAMETERS
//  IMEM_SIZE_WORDS  256      instruction array depth in 32-bit words (power of 2)
//  DMEM_SIZE_BYTES  1024     data array size in bytes (multiple of 4)
//  IMEM_WAIT        0        fixed wait cycles per fetch, 0..15
//  DMEM_WAIT        0        fixed wait cycles per data access, 0..15
//  LFSR_SEED        16'hACE1 stall-injection LFSR reset value (nonzero); used only with RV_MEM_STALL_INJECT_EN
// PORTS
//  clk                   in   1   core clock
//  rst                   in   1   synchronous active-high reset
//  fetch_req_Q100H       in   1   fetch request
//  pc_Q100H              in   32  fetch address; bits[1:0] ignored
//  instruction_Q101H     out  32  fetched word; valid when imem_ready_Q101H=1
//  imem_ready_Q101H      out  1   one-cycle fetch response pulse
//  imem_busy             out  1   fetch in wait state; new fetch requests ignored
//  dmem_rd_en_Q103H      in   1   load request
//  dmem_wr_en_Q103H      in   1   store request (wins if both rd and wr are set)
//  dmem_addr_Q103H       in   32  byte address
//  dmem_wr_data_Q103H    in   32  store data, lane-aligned
//  dmem_byte_en_Q103H    in   4   lane mask
//  dmem_is_signed_Q103H  in   1   1=sign-extend loads, 0=zero-extend
//  dmem_rd_data_Q104H    out  32  load data, shifted down and extended
//  dmem_ready_Q104H      out  1   one-cycle data response pulse (loads and stores)
//  dmem_busy             out  1   data access in wait state
//  dmem_err_Q104H        out  1   response was misaligned or out of range
// BEHAVIOUR
//  Per-port FSM with states IDLE and WAIT, plus a 4-bit down-counter.
//  Accept: request seen in cycle N while state=IDLE, or in the response cycle. Captured fields are held internally.
//  W=0: response in cycle N+1. W>0: state=WAIT for cycles N+1..N+W (busy=1), response in cycle N+W+1.
//  Throughput is 1 access per cycle at W=0. Requests presented while busy=1 are dropped; the core must hold them.
//  Response: ready=1 for exactly one cycle. instruction_Q101H and dmem_rd_data_Q104H hold their value until the next response.
//  IMEM index = pc[log2(IMEM_SIZE_WORDS)+1:2]; addresses wrap modulo the array size and never error.
//  Legal masks: 0001, 0010, 0100, 1000, 0011, 1100, 1111. The lowest set lane must equal addr[1:0].
//  Otherwise: misaligned. Also an error: addr >= DMEM_SIZE_BYTES.
//  On error: no write, rd_data=0, err=1 with the ready pulse.
//  Store: enabled lanes are written in the accept cycle. A load accepted next cycle sees the new data.
//  Store response: rd_data=0.
//  Load: selected lanes are shifted to bit 0; bits above the access width are sign/zero filled per is_signed.
//  IMEM and DMEM are fully independent; simultaneous accesses never conflict.
//  Reset values: ready, busy, err = 0; instruction_Q101H = 32'h00000013 (NOP); rd_data = 0; FSMs in IDLE.
//  Reset mid-WAIT: the access is aborted and no ready pulse follows. A store already accepted stays written.
//  Arrays are not cleared by reset (loaded by the bench via $readmemh on i_mem/d_mem).
// CONFIGURATION
//  RV_MEM_STALL_INJECT_EN defined:
//   16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1), reset to LFSR_SEED, advances every cycle.
//   On accept, wait = IMEM_WAIT + lfsr[1:0] (fetch) or DMEM_WAIT + lfsr[3:2] (data), saturating at 15.
//  Undefined: waits are exactly IMEM_WAIT / DMEM_WAIT; no LFSR logic.
// STRUCTURE
//  Package pkg gets: t_mem_state enum {MEM_IDLE, MEM_WAIT}; legal lane-mask localparams; function load_extend(data, mask, is_signed).
//  Sub-module rv_mem_port_fsm: accept/counter/ready/busy logic, parametrised by wait width.
//   Instantiated twice; the extra-wait input is tied to 0 when the macro is off.
//  Top contains the arrays i_mem.mem and d_mem.mem, lane/error decode, and the response registers.
// TESTING
//  1 IMEM_WAIT=0, mem[0]=0x00500093, fetch pc=0 in cycle 5 -> cycle 6: ready=1, instruction=0x00500093, busy=0 throughout.
//  2 IMEM_WAIT=3, fetch pc=0x4 in cycle 10 -> busy=1 in cycles 11-13; ready=1 only in cycle 14 with mem[1]; request at 12 ignored.
//  3 Store 0x00008000, mask 0010, addr 0x11; then signed load -> 0xFFFFFF80; unsigned load -> 0x00000080.
//  4 Mask 0011 at addr 0x2 -> err=1, rd_data=0, memory unchanged. Mask 0101 at addr 0x0 -> err=1.
//  5 DMEM_WAIT=4, rst=1 asserted in second WAIT cycle -> no ready pulse, busy=0 after reset; next load completes normally.
//  6 Load addr 0x400 with DMEM_SIZE_BYTES=1024 -> err=1, rd_data=0. Same-cycle fetch and store both respond correctly.

Source files
------------

// File: rtl/rv_mem_ws_pkg.sv
// Shared types, lane-mask constants and load extension helper for rv_mem_ws.
package rv_mem_ws_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned MEM_WAIT_W = 4;

  typedef enum logic [0:0] {
    MEM_IDLE = 1'b0,
    MEM_WAIT = 1'b1
  } t_mem_state;

  localparam logic [3:0] MASK_B0 = 4'b0001;
  localparam logic [3:0] MASK_B1 = 4'b0010;
  localparam logic [3:0] MASK_B2 = 4'b0100;
  localparam logic [3:0] MASK_B3 = 4'b1000;
  localparam logic [3:0] MASK_H0 = 4'b0011;
  localparam logic [3:0] MASK_H1 = 4'b1100;
  localparam logic [3:0] MASK_W  = 4'b1111;

  localparam logic [XLEN-1:0] INSN_NOP = 32'h0000_0013;

  // Captured data-port request fields.
  typedef struct packed {
    logic            store;
    logic            err;
    logic            is_signed;
    logic [3:0]      mask;
    logic [XLEN-1:0] addr;
  } t_dmem_req;

  // Lowest enabled lane of a legal mask.
  function automatic logic [1:0] mask_lane(input logic [3:0] mask);
    logic [1:0] lane;
    case (mask)
      MASK_B1:          lane = 2'd1;
      MASK_B2, MASK_H1: lane = 2'd2;
      MASK_B3:          lane = 2'd3;
      default:          lane = 2'd0;
    endcase
    return lane;
  endfunction

  // True for the seven supported byte/half/word masks.
  function automatic logic mask_legal(input logic [3:0] mask);
    logic ok;
    case (mask)
      MASK_B0, MASK_B1, MASK_B2, MASK_B3, MASK_H0, MASK_H1, MASK_W: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Shift the selected lanes down to bit 0 and sign/zero fill above them.
  function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] data,
                                                  input logic [3:0]      mask,
                                                  input logic            is_signed);
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] result;
    shifted = data >> {mask_lane(mask), 3'b000};
    case (mask)
      MASK_B0, MASK_B1, MASK_B2, MASK_B3:
        result = {{24{is_signed & shifted[7]}}, shifted[7:0]};
      MASK_H0, MASK_H1:
        result = {{16{is_signed & shifted[15]}}, shifted[15:0]};
      default:
        result = shifted;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/rv_mem_ws_if.sv
// Fetch and data port signals between the core (master) and rv_mem_ws (slave).
interface rv_mem_ws_if;
  logic        fetch_req_Q100H;
  logic [31:0] pc_Q100H;
  logic [31:0] instruction_Q101H;
  logic        imem_ready_Q101H;
  logic        imem_busy;

  logic        dmem_rd_en_Q103H;
  logic        dmem_wr_en_Q103H;
  logic [31:0] dmem_addr_Q103H;
  logic [31:0] dmem_wr_data_Q103H;
  logic [3:0]  dmem_byte_en_Q103H;
  logic        dmem_is_signed_Q103H;
  logic [31:0] dmem_rd_data_Q104H;
  logic        dmem_ready_Q104H;
  logic        dmem_busy;
  logic        dmem_err_Q104H;

  modport master (
    output fetch_req_Q100H, pc_Q100H,
    input  instruction_Q101H, imem_ready_Q101H, imem_busy,
    output dmem_rd_en_Q103H, dmem_wr_en_Q103H, dmem_addr_Q103H,
    output dmem_wr_data_Q103H, dmem_byte_en_Q103H, dmem_is_signed_Q103H,
    input  dmem_rd_data_Q104H, dmem_ready_Q104H, dmem_busy, dmem_err_Q104H
  );

  modport slave (
    input  fetch_req_Q100H, pc_Q100H,
    output instruction_Q101H, imem_ready_Q101H, imem_busy,
    input  dmem_rd_en_Q103H, dmem_wr_en_Q103H, dmem_addr_Q103H,
    input  dmem_wr_data_Q103H, dmem_byte_en_Q103H, dmem_is_signed_Q103H,
    output dmem_rd_data_Q104H, dmem_ready_Q104H, dmem_busy, dmem_err_Q104H
  );
endinterface

// File: rtl/rv_mem_port_fsm.sv
// Per-port accept / wait-state / response sequencer (IDLE, WAIT + down-counter).
module rv_mem_port_fsm
  import rv_mem_ws_pkg::*;
#(
  parameter int unsigned WAIT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [WAIT_W-1:0] wait_base,
  input  logic [WAIT_W-1:0] wait_extra,
  output logic              accept_c,
  output logic              respond_c,
  output logic              ready,
  output logic              busy
);

  t_mem_state        state, state_next;
  logic [WAIT_W-1:0] cnt, cnt_next;
  logic [WAIT_W:0]   wait_sum_c;
  logic [WAIT_W-1:0] wait_c;

  // Effective wait for this access, saturating at the counter maximum.
  always_comb begin
    wait_sum_c = {1'b0, wait_base} + {1'b0, wait_extra};
    wait_c     = wait_sum_c[WAIT_W] ? '1 : wait_sum_c[WAIT_W-1:0];
  end

  // State, counter and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= MEM_IDLE;
      cnt   <= '0;
      ready <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      ready <= respond_c;
      busy  <= (state_next == MEM_WAIT);
    end
  end

  // Next-state: enter WAIT on a delayed accept, leave when the count expires.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      MEM_IDLE: begin
        if (req && (wait_c != '0)) begin
          state_next = MEM_WAIT;
          cnt_next   = wait_c;
        end
      end
      MEM_WAIT: begin
        cnt_next = cnt - WAIT_W'(1);
        if (cnt == WAIT_W'(1)) begin
          state_next = MEM_IDLE;
        end
      end
      default: state_next = MEM_IDLE;
    endcase
  end

  // Accept strobe and the cycle whose edge produces the response.
  always_comb begin
    accept_c  = 1'b0;
    respond_c = 1'b0;
    case (state)
      MEM_IDLE: begin
        accept_c  = req;
        respond_c = req && (wait_c == '0);
      end
      MEM_WAIT: respond_c = (cnt == WAIT_W'(1));
      default: ;
    endcase
  end

endmodule

// File: rtl/rv_mem_ws.sv
// Instruction/data memory with per-port wait states for the 5-stage core.
// Optional build macro: RV_MEM_STALL_INJECT_EN adds LFSR-driven extra wait cycles.
module rv_mem_ws
  import rv_mem_ws_pkg::*;
#(
  parameter int unsigned IMEM_SIZE_WORDS = 256,
  parameter int unsigned DMEM_SIZE_BYTES = 1024,
  parameter int unsigned IMEM_WAIT       = 0,
  parameter int unsigned DMEM_WAIT       = 0,
  parameter int unsigned LFSR_SEED       = 16'hACE1
) (
  input  logic         clk,
  input  logic         rst,
  rv_mem_ws_if.slave   bus
);

  localparam int unsigned IA_W = $clog2(IMEM_SIZE_WORDS);
  localparam int unsigned DA_W = $clog2(DMEM_SIZE_BYTES);

  logic [MEM_WAIT_W-1:0] i_extra, d_extra;
  logic                  i_accept_c, i_respond_c;
  logic                  d_accept_c, d_respond_c;
  logic                  d_req_c;
  logic [IA_W-1:0]       pc_idx_q, pc_idx_c;
  t_dmem_req             d_live_c, d_q, d_eff_c;
  logic [DA_W-3:0]       widx_c;
  logic [XLEN-1:0]       rd_word_c;
  logic                  unused_c;

  if (1) begin : i_mem
    logic [XLEN-1:0] mem [IMEM_SIZE_WORDS];
  end

`ifdef RV_MEM_STALL_INJECT_EN
  logic [15:0] lfsr;

  // Free-running x^16+x^14+x^13+x^11+1 LFSR for random extra waits.
  always_ff @(posedge clk) begin
    if (rst) lfsr <= 16'(LFSR_SEED);
    else     lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign i_extra = {2'b00, lfsr[1:0]};
  assign d_extra = {2'b00, lfsr[3:2]};
`else
  logic [31:0] unused_seed;
  assign unused_seed = 32'(LFSR_SEED);
  assign i_extra     = '0;
  assign d_extra     = '0;
`endif

  rv_mem_port_fsm #(.WAIT_W(MEM_WAIT_W)) u_ifsm (
    .clk        (clk),
    .rst        (rst),
    .req        (bus.fetch_req_Q100H),
    .wait_base  (MEM_WAIT_W'(IMEM_WAIT)),
    .wait_extra (i_extra),
    .accept_c   (i_accept_c),
    .respond_c  (i_respond_c),
    .ready      (bus.imem_ready_Q101H),
    .busy       (bus.imem_busy)
  );

  assign d_req_c = bus.dmem_rd_en_Q103H | bus.dmem_wr_en_Q103H;

  rv_mem_port_fsm #(.WAIT_W(MEM_WAIT_W)) u_dfsm (
    .clk        (clk),
    .rst        (rst),
    .req        (d_req_c),
    .wait_base  (MEM_WAIT_W'(DMEM_WAIT)),
    .wait_extra (d_extra),
    .accept_c   (d_accept_c),
    .respond_c  (d_respond_c),
    .ready      (bus.dmem_ready_Q104H),
    .busy       (bus.dmem_busy)
  );

  // Fetch index: live on a zero-wait accept, captured otherwise.
  assign pc_idx_c = i_accept_c ? bus.pc_Q100H[IA_W+1:2] : pc_idx_q;

  // Live data request decode including misalign and range errors.
  always_comb begin
    d_live_c.store     = bus.dmem_wr_en_Q103H;
    d_live_c.is_signed = bus.dmem_is_signed_Q103H;
    d_live_c.mask      = bus.dmem_byte_en_Q103H;
    d_live_c.addr      = bus.dmem_addr_Q103H;
    d_live_c.err       = !mask_legal(bus.dmem_byte_en_Q103H)
                      || (mask_lane(bus.dmem_byte_en_Q103H) != bus.dmem_addr_Q103H[1:0])
                      || (bus.dmem_addr_Q103H >= 32'(DMEM_SIZE_BYTES));
  end

  assign d_eff_c = d_accept_c ? d_live_c : d_q;
  assign widx_c  = d_eff_c.addr[DA_W-1:2];

  if (1) begin : d_mem
    logic [7:0] mem [DMEM_SIZE_BYTES];

    // Stores write their enabled lanes at the end of the accept cycle.
    always_ff @(posedge clk) begin
      if (!rst && d_accept_c && d_live_c.store && !d_live_c.err) begin
        for (int l = 0; l < 4; l++) begin
          if (d_live_c.mask[l]) begin
            mem[{d_live_c.addr[DA_W-1:2], 2'(l)}] <= bus.dmem_wr_data_Q103H[8*l +: 8];
          end
        end
      end
    end
  end

  assign rd_word_c = {d_mem.mem[{widx_c, 2'd3}], d_mem.mem[{widx_c, 2'd2}],
                      d_mem.mem[{widx_c, 2'd1}], d_mem.mem[{widx_c, 2'd0}]};

  // Hold request fields across wait states.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_idx_q <= '0;
      d_q      <= '0;
    end else begin
      if (i_accept_c) pc_idx_q <= bus.pc_Q100H[IA_W+1:2];
      if (d_accept_c) d_q      <= d_live_c;
    end
  end

  // Response data registers; payloads hold until the next response.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.instruction_Q101H  <= INSN_NOP;
      bus.dmem_rd_data_Q104H <= '0;
      bus.dmem_err_Q104H     <= 1'b0;
    end else begin
      if (i_respond_c) bus.instruction_Q101H <= i_mem.mem[pc_idx_c];
      bus.dmem_err_Q104H <= d_respond_c & d_eff_c.err;
      if (d_respond_c) begin
        bus.dmem_rd_data_Q104H <= (d_eff_c.err || d_eff_c.store) ? '0
                                : load_extend(rd_word_c, d_eff_c.mask, d_eff_c.is_signed);
      end
    end
  end

  assign unused_c = ^{bus.pc_Q100H, d_eff_c.addr};

endmodule

// File: tb/tb_rv_mem_ws.sv
// Directed bench for rv_mem_ws: zero-wait and wait-state instances side by side.
module tb_rv_mem_ws;

  logic clk = 1'b0;
  logic rst0, rst1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  rv_mem_ws_if bus0 ();
  rv_mem_ws_if bus1 ();

  rv_mem_ws #(.IMEM_WAIT(0), .DMEM_WAIT(0)) u_dut0 (.clk(clk), .rst(rst0), .bus(bus0));
  rv_mem_ws #(.IMEM_WAIT(3), .DMEM_WAIT(4)) u_dut1 (.clk(clk), .rst(rst1), .bus(bus1));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic d0_set(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] mask, input logic sgn);
    bus0.dmem_rd_en_Q103H     = rd;
    bus0.dmem_wr_en_Q103H     = wr;
    bus0.dmem_addr_Q103H      = addr;
    bus0.dmem_wr_data_Q103H   = wdata;
    bus0.dmem_byte_en_Q103H   = mask;
    bus0.dmem_is_signed_Q103H = sgn;
  endtask

  // One zero-wait data access on dut0, checking the response.
  task automatic d0_access(input string tag, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] mask, input logic sgn,
                           input logic [31:0] exp_data, input logic exp_err);
    d0_set(~wr, wr, addr, wdata, mask, sgn);
    tick();
    d0_set(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    check_eq({tag, "_rdy"}, 32'(bus0.dmem_ready_Q104H), 32'd1);
    check_eq({tag, "_err"}, 32'(bus0.dmem_err_Q104H), 32'(exp_err));
    check_eq({tag, "_data"}, bus0.dmem_rd_data_Q104H, exp_data);
  endtask

  task automatic d1_set(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata);
    bus1.dmem_rd_en_Q103H     = rd;
    bus1.dmem_wr_en_Q103H     = wr;
    bus1.dmem_addr_Q103H      = addr;
    bus1.dmem_wr_data_Q103H   = wdata;
    bus1.dmem_byte_en_Q103H   = 4'b1111;
    bus1.dmem_is_signed_Q103H = 1'b0;
  endtask

  // Bounded wait for a dut1 data response; returns cycles since the accept or -1.
  task automatic d1_wait(output int lat);
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c == 1) d1_set(1'b0, 1'b0, 32'h0, 32'h0);
      if (bus1.dmem_ready_Q104H) begin
        lat = c;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int pulses;
    bus0.fetch_req_Q100H = 1'b0;
    bus0.pc_Q100H        = 32'h0;
    bus1.fetch_req_Q100H = 1'b0;
    bus1.pc_Q100H        = 32'h0;
    d0_set(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    d1_set(1'b0, 1'b0, 32'h0, 32'h0);
    rst0 = 1'b1;
    rst1 = 1'b1;
    u_dut0.i_mem.mem[0] = 32'h0050_0093;
    u_dut0.i_mem.mem[1] = 32'h00a0_0113;
    u_dut1.i_mem.mem[0] = 32'h0050_0093;
    u_dut1.i_mem.mem[1] = 32'h00a0_0113;
    repeat (3) tick();

    check_eq("rst_insn",  bus0.instruction_Q101H, 32'h0000_0013);
    check_eq("rst_irdy",  32'(bus0.imem_ready_Q101H), 32'd0);
    check_eq("rst_ibusy", 32'(bus1.imem_busy), 32'd0);
    check_eq("rst_drdy",  32'(bus0.dmem_ready_Q104H), 32'd0);
    check_eq("rst_derr",  32'(bus0.dmem_err_Q104H), 32'd0);
    check_eq("rst_rdata", bus0.dmem_rd_data_Q104H, 32'h0);
    rst0 = 1'b0;
    rst1 = 1'b0;
    tick();

    // Zero-wait fetch.
    bus0.fetch_req_Q100H = 1'b1;
    bus0.pc_Q100H        = 32'h0;
    tick();
    bus0.fetch_req_Q100H = 1'b0;
    check_eq("f0_rdy",  32'(bus0.imem_ready_Q101H), 32'd1);
    check_eq("f0_insn", bus0.instruction_Q101H, 32'h0050_0093);
    check_eq("f0_busy", 32'(bus0.imem_busy), 32'd0);
    tick();
    check_eq("f0_pulse", 32'(bus0.imem_ready_Q101H), 32'd0);
    check_eq("f0_hold",  bus0.instruction_Q101H, 32'h0050_0093);

    // Three-wait fetch; a request during busy is dropped.
    bus1.fetch_req_Q100H = 1'b1;
    bus1.pc_Q100H        = 32'h4;
    tick();
    bus1.fetch_req_Q100H = 1'b0;
    check_eq("f3_busy1", 32'(bus1.imem_busy), 32'd1);
    check_eq("f3_rdy1",  32'(bus1.imem_ready_Q101H), 32'd0);
    bus1.fetch_req_Q100H = 1'b1;
    bus1.pc_Q100H        = 32'h0;
    tick();
    bus1.fetch_req_Q100H = 1'b0;
    check_eq("f3_busy2", 32'(bus1.imem_busy), 32'd1);
    tick();
    check_eq("f3_busy3", 32'(bus1.imem_busy), 32'd1);
    check_eq("f3_rdy3",  32'(bus1.imem_ready_Q101H), 32'd0);
    tick();
    check_eq("f3_rdy",  32'(bus1.imem_ready_Q101H), 32'd1);
    check_eq("f3_insn", bus1.instruction_Q101H, 32'h00a0_0113);
    check_eq("f3_idle", 32'(bus1.imem_busy), 32'd0);
    tick();
    check_eq("f3_drop_rdy",  32'(bus1.imem_ready_Q101H), 32'd0);
    check_eq("f3_drop_busy", 32'(bus1.imem_busy), 32'd0);
    check_eq("f3_hold",      bus1.instruction_Q101H, 32'h00a0_0113);

    // Byte and halfword lanes with sign/zero extension.
    d0_access("st_b1",  1'b1, 32'h11, 32'h0000_8000, 4'b0010, 1'b0, 32'h0, 1'b0);
    d0_access("ld_b1s", 1'b0, 32'h11, 32'h0,         4'b0010, 1'b1, 32'hFFFF_FF80, 1'b0);
    d0_access("ld_b1u", 1'b0, 32'h11, 32'h0,         4'b0010, 1'b0, 32'h0000_0080, 1'b0);
    d0_access("st_w",   1'b1, 32'h20, 32'h1122_3344, 4'b1111, 1'b0, 32'h0, 1'b0);
    d0_access("ld_h1s", 1'b0, 32'h22, 32'h0,         4'b1100, 1'b1, 32'h0000_1122, 1'b0);
    d0_access("ld_b3u", 1'b0, 32'h23, 32'h0,         4'b1000, 1'b0, 32'h0000_0011, 1'b0);
    d0_access("ld_h0s", 1'b0, 32'h20, 32'h0,         4'b0011, 1'b1, 32'h0000_3344, 1'b0);
    d0_access("st_h1",  1'b1, 32'h22, 32'h8001_0000, 4'b1100, 1'b0, 32'h0, 1'b0);
    d0_access("ld_h1n", 1'b0, 32'h22, 32'h0,         4'b1100, 1'b1, 32'hFFFF_8001, 1'b0);
    d0_access("ld_w2",  1'b0, 32'h20, 32'h0,         4'b1111, 1'b0, 32'h8001_3344, 1'b0);

    // Misaligned and illegal masks.
    d0_access("st_w0",   1'b1, 32'h0, 32'hA5A5_A5A5, 4'b1111, 1'b0, 32'h0, 1'b0);
    d0_access("mis_st",  1'b1, 32'h2, 32'h0000_FFFF, 4'b0011, 1'b0, 32'h0, 1'b1);
    d0_access("ld_w0",   1'b0, 32'h0, 32'h0,         4'b1111, 1'b0, 32'hA5A5_A5A5, 1'b0);
    d0_access("bad_msk", 1'b0, 32'h0, 32'h0,         4'b0101, 1'b0, 32'h0, 1'b1);
    d0_access("mis_w",   1'b0, 32'h1, 32'h0,         4'b1111, 1'b0, 32'h0, 1'b1);

    // Range boundary.
    d0_access("oor_ld",  1'b0, 32'h400, 32'h0,         4'b1111, 1'b0, 32'h0, 1'b1);
    d0_access("top_st",  1'b1, 32'h3FC, 32'hCAFE_F00D, 4'b1111, 1'b0, 32'h0, 1'b0);
    d0_access("top_ld",  1'b0, 32'h3FC, 32'h0,         4'b1111, 1'b0, 32'hCAFE_F00D, 1'b0);
    tick();
    check_eq("err_pulse", 32'(bus0.dmem_err_Q104H), 32'd0);

    // Fetch wraps; same-cycle fetch and store.
    bus0.fetch_req_Q100H = 1'b1;
    bus0.pc_Q100H        = 32'h404;
    d0_set(1'b0, 1'b1, 32'h8, 32'h1357_9BDF, 4'b1111, 1'b0);
    tick();
    bus0.fetch_req_Q100H = 1'b0;
    d0_set(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    check_eq("both_irdy", 32'(bus0.imem_ready_Q101H), 32'd1);
    check_eq("both_insn", bus0.instruction_Q101H, 32'h00a0_0113);
    check_eq("both_drdy", 32'(bus0.dmem_ready_Q104H), 32'd1);
    d0_access("both_ld", 1'b0, 32'h8, 32'h0, 4'b1111, 1'b0, 32'h1357_9BDF, 1'b0);

    // Four-wait data port: latency, reset abort, store survives.
    d1_set(1'b0, 1'b1, 32'h10, 32'h1234_5678);
    d1_wait(lat);
    check_eq("d4_st_lat", 32'(lat), 32'd5);
    d1_set(1'b0, 1'b1, 32'h14, 32'h0BAD_F00D);
    tick();
    d1_set(1'b0, 1'b0, 32'h0, 32'h0);
    check_eq("d4_busy", 32'(bus1.dmem_busy), 32'd1);
    tick();
    rst1 = 1'b1;
    tick();
    rst1 = 1'b0;
    check_eq("d4_rst_busy", 32'(bus1.dmem_busy), 32'd0);
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (bus1.dmem_ready_Q104H) pulses++;
    end
    check_eq("d4_abort", 32'(pulses), 32'd0);
    d1_set(1'b1, 1'b0, 32'h10, 32'h0);
    d1_wait(lat);
    check_eq("d4_ld_lat",  32'(lat), 32'd5);
    check_eq("d4_ld_data", bus1.dmem_rd_data_Q104H, 32'h1234_5678);
    d1_set(1'b1, 1'b0, 32'h14, 32'h0);
    d1_wait(lat);
    check_eq("d4_kept_lat",  32'(lat), 32'd5);
    check_eq("d4_kept_data", bus1.dmem_rd_data_Q104H, 32'h0BAD_F00D);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
